// File: rtl/seq_mult_ctrl.sv
// Unsigned shift-and-add multiplier: one N-bit ripple adder reused over N iterations.
// Latency: N+2 cycles from accepted start to the next possible start; done pulses once.
// Backpressure: none; start is ignored while busy, product holds until the next accepted start.

module full_adder_str (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

// Structural N-bit ripple-carry adder built from a chain of full adders.
// Latency: combinational. Backpressure: none.
// Sum and carry-out are valid once the carry has rippled through all N stages.
module NBitAdder_str #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum,
  output logic         c_out
);
  logic [N:0] carry;

  assign carry[0] = c_in;
  assign c_out    = carry[N];

  for (genvar i = 0; i < N; i++) begin : g_fa
    full_adder_str u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (carry[i]),
      .s  (sum[i]),
      .co (carry[i+1])
    );
  end
endmodule

// Sequential multiplier controller: start/busy/done handshake around a time-shared adder.
// Latency: N iterations after the start edge, then one DONE cycle, then IDLE.
// Backpressure: start is only sampled in IDLE; requests while busy are dropped.
module seq_mult_ctrl #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);
  localparam int CW = $clog2(N) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]   state;
  logic [N-1:0] m_reg;
  logic [N-1:0] p_hi;
  logic [N-1:0] p_lo;
  logic [CW-1:0] cnt;

  logic [N-1:0] addend;
  logic [N-1:0] sum;
  logic         c_out;
  logic [2*N-1:0] p_next;

  // The multiplier bit under inspection gates the multiplicand into the adder.
  assign addend = p_lo[0] ? m_reg : '0;

  NBitAdder_str #(.N(N)) u_adder (
    .a     (p_hi),
    .b     (addend),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // Carry lands in the MSB after the right shift, so no product bit is ever lost.
  assign p_next = {c_out, sum, p_lo[N-1:1]};

  assign busy = (state == S_RUN) || (state == S_DONE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      m_reg   <= '0;
      p_hi    <= '0;
      p_lo    <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            m_reg <= a;
            p_hi  <= '0;
            p_lo  <= b;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          p_hi <= p_next[2*N-1:N];
          p_lo <= p_next[N-1:0];
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            product <= p_next;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed checks of seq_mult_ctrl at N=8 plus a randomised back-to-back run at N=32.
module tb_seq_mult_ctrl;
  logic        clk;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;

  logic        start32;
  logic [31:0] a32, b32;
  logic        busy32, done32;
  logic [63:0] prod32;

  int n_assert = 0;
  int n_fail   = 0;

  seq_mult_ctrl #(.N(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start8),
    .a       (a8),
    .b       (b8),
    .busy    (busy8),
    .done    (done8),
    .product (prod8)
  );

  seq_mult_ctrl #(.N(32)) dut32 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start32),
    .a       (a32),
    .b       (b32),
    .busy    (busy32),
    .done    (done32),
    .product (prod32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_v,
                      input logic [15:0] exp, input string tag);
    int cyc;
    start8 = 1'b1; a8 = ta; b8 = tb_v;
    tick();
    start8 = 1'b0; a8 = '0; b8 = '0;
    chk({tag, "_busy_rise"}, 64'(busy8), 64'd1);
    cyc = 0;
    while (!done8 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'd8);
    chk({tag, "_product"}, 64'(prod8), 64'(exp));
    tick();
    chk({tag, "_done_fall"}, 64'(done8), 64'd0);
    chk({tag, "_busy_fall"}, 64'(busy8), 64'd0);
  endtask

  initial begin
    int cyc;
    int dones;
    logic [31:0] ra, rb;
    logic [63:0] rexp;

    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;

    // Test 1: reset values, basic multiply, product held through idle
    tick(); tick();
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_product", 64'(prod8), 64'd0);
    rst_n = 1'b1;
    tick();
    run8(8'd3, 8'd5, 16'd15, "t1");
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold", 64'(prod8), 64'd15);
    end

    // Test 2: all-ones operands and the carry-into-MSB path
    run8(8'hFF, 8'hFF, 16'hFE01, "t2_ff");
    run8(8'h80, 8'h02, 16'h0100, "t2_carry");

    // Test 3: zero operands still take the full latency
    run8(8'h00, 8'hA5, 16'h0000, "t3_a0");
    run8(8'hA5, 8'h00, 16'h0000, "t3_b0");

    // Test 4: start pulses while busy are ignored
    dones = 0;
    start8 = 1'b1; a8 = 8'd7; b8 = 8'd9;
    tick();
    start8 = 1'b0;
    tick(); tick();
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      tick();
      cyc++;
    end
    chk("t4_latency", 64'(cyc), 64'd5);
    if (done8) dones++;
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd2;
    tick();
    start8 = 1'b0;
    chk("t4_busy_after_done", 64'(busy8), 64'd0);
    for (int i = 0; i < 12; i++) begin
      if (done8) dones++;
      tick();
    end
    chk("t4_done_count", 64'(dones), 64'd1);
    chk("t4_product", 64'(prod8), 64'd63);
    chk("t4_idle", 64'(busy8), 64'd0);

    // Test 5: reset mid-operation aborts, then a clean multiply
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t5_rst_busy", 64'(busy8), 64'd0);
    chk("t5_rst_done", 64'(done8), 64'd0);
    chk("t5_rst_product", 64'(prod8), 64'd0);
    run8(8'd12, 8'd12, 16'd144, "t5");

    // Test 6: N=32 back-to-back random operands against a 64-bit reference
    dones = 0;
    for (int k = 0; k < 500; k++) begin
      ra = $urandom;
      rb = $urandom;
      if (k == 0) begin ra = 32'hFFFF_FFFF; rb = 32'hFFFF_FFFF; end
      rexp = 64'(ra) * 64'(rb);
      start32 = 1'b1; a32 = ra; b32 = rb;
      tick();
      start32 = 1'b0;
      cyc = 0;
      while (!done32 && cyc < 80) begin
        tick();
        cyc++;
      end
      if (done32) dones++;
      chk("t6_latency", 64'(cyc), 64'd32);
      chk("t6_product", prod32, rexp);
      tick();
    end
    chk("t6_done_count", 64'(dones), 64'd500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
